// File: rtl/uart_rx_frame18_pkg.sv
// Shared constants and FSM state encoding for the sensor-link UART (receiver and transmitter).
package uart_rx_frame18_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 576;
    localparam int unsigned UART_DATA_BITS    = 18;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic uart_rxd,
    output logic rxs
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], uart_rxd};
        end
    end

    assign rxs = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame18.sv
// 20-bit frame UART receiver (start, 18 data bits LSB first, stop) with valid/ack handshake.
module uart_rx_frame18
    import uart_rx_frame18_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    input  logic                 uart_rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;

    uart_rx_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .uart_rxd (uart_rxd),
        .rxs      (rxs)
    );

    // Frame FSM, bit timing, shift register and consumer handshake.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        clk_cnt <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt          <= '0;
                        shift_q[bit_idx] <= rxs;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rxs) begin
                            // A same-cycle ack releases the old frame, so no overrun.
                            rx_data    <= shift_q;
                            rx_valid   <= 1'b1;
                            rx_overrun <= rx_valid & ~rx_ack;
                            state      <= IDLE;
                            rx_busy    <= 1'b0;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame18.sv
// Scoreboard bench for uart_rx_frame18: serial stimulus with a frame-level reference model.
module tb_uart_rx_frame18;

    localparam int CPB = 100;
    localparam int DW  = 18;

    logic          sys_clk   = 1'b0;
    logic          sys_reset = 1'b1;
    logic          uart_rxd  = 1'b1;
    logic          rx_ack    = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_overrun;
    logic          rx_busy;

    int            n_cmp     = 0;
    int            n_bad     = 0;
    int            exp_err   = 0;
    int            err_seen  = 0;
    bit            auto_ack  = 1'b0;
    bit            manual_ack = 1'b0;
    logic [DW-1:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    uart_rx_frame18 #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DW),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .uart_rxd    (uart_rxd),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        uart_rxd = b;
        repeat (n) @(negedge sys_clk);
    endtask

    // Reference model: a good stop bit yields exactly the sent word, a bad one one error.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int n);
        if (stop) exp_q.push_back(d);
        else      exp_err++;
        drive_bit(1'b0, n);
        for (int i = 0; i < DW; i++) drive_bit(d[i], n);
        drive_bit(stop, n);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget && !rx_valid; i++) @(negedge sys_clk);
        n_cmp++;
        if (!rx_valid) begin
            n_bad++;
            $display("FAIL %s: rx_valid got 0, expected 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_ack();
        #1 manual_ack = 1'b1;
        @(negedge sys_clk);
        #1 manual_ack = 1'b0;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},    32'(rx_data), 32'h0);
        check({tag, "_valid"},   32'(rx_valid), 32'h0);
        check({tag, "_ferr"},    32'(rx_frame_err), 32'h0);
        check({tag, "_overrun"}, 32'(rx_overrun), 32'h0);
        check({tag, "_busy"},    32'(rx_busy), 32'h0);
    endtask

    // Ack driver: automatic one-cycle ack per frame, or manual pulses from the main sequence.
    initial begin
        forever begin
            @(negedge sys_clk);
            rx_ack = auto_ack ? (rx_valid && !rx_ack) : manual_ack;
        end
    end

    // Monitor: every newly presented frame is popped from the scoreboard and compared.
    initial begin
        logic          v_prev;
        logic [DW-1:0] d_prev;
        logic [DW-1:0] e;
        v_prev = 1'b0;
        d_prev = '0;
        forever begin
            @(negedge sys_clk);
            if (rx_frame_err) err_seen++;
            if (rx_valid && (!v_prev || rx_data != d_prev)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", 32'(rx_data), 32'(e));
                end
            end
            v_prev = rx_valid;
            d_prev = rx_data;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d_before;
        logic [DW-1:0] part;
        logic          v_before;
        int            busy_cnt;
        int            n;
        int            gap;
        logic          stop;

        repeat (3) @(negedge sys_clk);
        #1 check_reset_outputs("reset");
        sys_reset = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Single good frame, held without ack.
        send_frame(18'h2AAAA, 1'b1, CPB);
        wait_valid("t1_valid", 4 * CPB);
        check("t1_data", 32'(rx_data), 32'(18'h2AAAA));
        check("t1_busy", 32'(rx_busy), 32'h0);
        check("t1_ferr_count", 32'(err_seen), 32'(exp_err));
        pulse_ack();
        check("t1_valid_after_ack", 32'(rx_valid), 32'h0);

        // Short low glitch: START lasts half a bit, then rejected silently.
        busy_cnt = 0;
        uart_rxd = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (i == 30) uart_rxd = 1'b1;
            @(negedge sys_clk);
            if (rx_busy) busy_cnt++;
        end
        check("t2_busy_cycles", 32'(busy_cnt), 32'(CPB / 2));
        check("t2_valid", 32'(rx_valid), 32'h0);
        check("t2_ferr_count", 32'(err_seen), 32'(exp_err));

        // Bad stop bit followed by a long break: one error, outputs untouched.
        d_before = rx_data;
        v_before = rx_valid;
        send_frame(18'h00F0F, 1'b0, CPB);
        drive_bit(1'b0, 2000);
        drive_bit(1'b1, 10);
        check("t3_ferr_count", 32'(err_seen), 32'(exp_err));
        check("t3_data_kept", 32'(rx_data), 32'(d_before));
        check("t3_valid_kept", 32'(rx_valid), 32'(v_before));
        send_frame(18'h1B2C3, 1'b1, CPB);
        wait_valid("t3_next_valid", 4 * CPB);
        check("t3_next_data", 32'(rx_data), 32'(18'h1B2C3));
        pulse_ack();

        // Back-to-back frames without ack -> overrun.
        send_frame(18'h00001, 1'b1, CPB);
        wait_valid("t4_first_valid", 4 * CPB);
        check("t4_overrun_before", 32'(rx_overrun), 32'h0);
        send_frame(18'h3FFFF, 1'b1, CPB);
        repeat (2) @(negedge sys_clk);
        check("t4_overrun", 32'(rx_overrun), 32'h1);
        check("t4_data", 32'(rx_data), 32'(18'h3FFFF));
        check("t4_valid", 32'(rx_valid), 32'h1);
        pulse_ack();
        check("t4_valid_after_ack", 32'(rx_valid), 32'h0);
        check("t4_overrun_after_ack", 32'(rx_overrun), 32'h0);

        // Reset during data bit 7 with a frame pending.
        send_frame(18'h00155, 1'b1, CPB);
        wait_valid("t5_pending_valid", 4 * CPB);
        part = 18'h3A5A5;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 7; i++) drive_bit(part[i], CPB);
        uart_rxd = part[7];
        repeat (CPB / 2) @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        sys_reset = 1'b0;
        uart_rxd  = 1'b1;
        #1 check_reset_outputs("t5_reset");
        repeat (3 * CPB) @(negedge sys_clk);
        check("t5_no_partial_commit", 32'(rx_valid), 32'h0);
        send_frame(18'h12345, 1'b1, CPB);
        wait_valid("t5_next_valid", 4 * CPB);
        check("t5_next_data", 32'(rx_data), 32'(18'h12345));
        pulse_ack();

        // Loopback with +-2% sender clock skew, auto-acked.
        auto_ack = 1'b1;
        for (int f = 0; f < 6; f++) begin
            n   = int'($urandom_range(CPB + 2, CPB - 2));
            gap = int'($urandom_range(20, 0));
            send_frame(18'h2C3A5, 1'b1, n);
            drive_bit(1'b1, gap);
        end

        // Randomised payloads, occasional bad stop bits.
        for (int f = 0; f < 12; f++) begin
            n    = int'($urandom_range(CPB + 2, CPB - 2));
            gap  = int'($urandom_range(40, 0));
            stop = ($urandom_range(4, 0) != 0);
            if (!stop) gap += n;
            send_frame(DW'($urandom), stop, n);
            drive_bit(1'b1, gap);
        end

        repeat (3 * CPB) @(negedge sys_clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_ferr_count", 32'(err_seen), 32'(exp_err));
        check("final_overrun", 32'(rx_overrun), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
